// File: rtl/ram_access_ctrl.sv
// Two-requester (fetch / load-store) controller in front of a single-port RAM
// with registered inputs and one-cycle read latency; round-robin on contention.
module ram_access_ctrl #(
    parameter int AW = 8,
    parameter int DW = 16
) (
    input  logic          Clk,
    input  logic          ResetN,
    input  logic          D_Req,
    input  logic          D_We,
    input  logic [AW-1:0] D_Addr,
    input  logic [DW-1:0] D_WData,
    output logic          D_Gnt,
    output logic          D_RValid,
    output logic [DW-1:0] D_RData,
    output logic          D_WDone,
    input  logic          F_Req,
    input  logic [AW-1:0] F_Addr,
    output logic          F_Gnt,
    output logic          F_RValid,
    output logic [DW-1:0] F_RData,
    output logic [AW-1:0] RamAddr,
    output logic [DW-1:0] RamData,
    output logic          RamWren,
    input  logic [DW-1:0] RamQ
);

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;

    state_t r_state, w_next;
    logic   r_prio_f;   // 1 = fetch wins the next tie (data was served last)
    logic   r_own_f;
    logic   r_we;
    logic   w_d_win, w_f_win;

    always_comb begin
        w_next  = r_state;
        w_d_win = 1'b0;
        w_f_win = 1'b0;
        case (r_state)
            IDLE: begin
                if (D_Req && (!F_Req || !r_prio_f)) w_d_win = 1'b1;
                else if (F_Req)                     w_f_win = 1'b1;
                if (D_Req || F_Req) w_next = ISSUE;
            end
            ISSUE:   w_next = r_we ? IDLE : CAPTURE;
            CAPTURE: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    assign D_Gnt = w_d_win;
    assign F_Gnt = w_f_win;

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) r_state <= IDLE;
        else         r_state <= w_next;
    end

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            RamAddr  <= '0;
            RamData  <= '0;
            RamWren  <= 1'b0;
            D_RData  <= '0;
            F_RData  <= '0;
            D_RValid <= 1'b0;
            F_RValid <= 1'b0;
            D_WDone  <= 1'b0;
            r_prio_f <= 1'b0;
            r_own_f  <= 1'b0;
            r_we     <= 1'b0;
        end else begin
            D_RValid <= 1'b0;
            F_RValid <= 1'b0;
            D_WDone  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_d_win || w_f_win) begin
                        RamAddr  <= w_d_win ? D_Addr : F_Addr;
                        if (w_d_win && D_We) RamData <= D_WData;
                        RamWren  <= w_d_win & D_We;
                        r_we     <= w_d_win & D_We;
                        r_own_f  <= w_f_win;
                        r_prio_f <= w_d_win;
                    end else begin
                        RamWren <= 1'b0;
                    end
                end
                ISSUE: begin
                    // RAM samples wren at this edge; drop it so each write is one cycle.
                    RamWren <= 1'b0;
                    if (r_we) D_WDone <= 1'b1;
                end
                CAPTURE: begin
                    if (r_own_f) begin
                        F_RData  <= RamQ;
                        F_RValid <= 1'b1;
                    end else begin
                        D_RData  <= RamQ;
                        D_RValid <= 1'b1;
                    end
                end
                default: RamWren <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Bench for ram_access_ctrl: behavioural RAM, table of accesses plus
// hand sequences for arbitration and mid-transaction reset.
module tb_ram_access_ctrl;

    logic        Clk = 1'b0;
    logic        ResetN = 1'b0;
    logic        D_Req = 1'b0, D_We = 1'b0, F_Req = 1'b0;
    logic [7:0]  D_Addr = '0, F_Addr = '0;
    logic [15:0] D_WData = '0;
    logic        D_Gnt, D_RValid, D_WDone, F_Gnt, F_RValid, RamWren;
    logic [15:0] D_RData, F_RData, RamData;
    logic [15:0] RamQ;
    logic [7:0]  RamAddr;

    ram_access_ctrl #(.AW(8), .DW(16)) dut (
        .Clk(Clk), .ResetN(ResetN),
        .D_Req(D_Req), .D_We(D_We), .D_Addr(D_Addr), .D_WData(D_WData),
        .D_Gnt(D_Gnt), .D_RValid(D_RValid), .D_RData(D_RData), .D_WDone(D_WDone),
        .F_Req(F_Req), .F_Addr(F_Addr), .F_Gnt(F_Gnt), .F_RValid(F_RValid),
        .F_RData(F_RData), .RamAddr(RamAddr), .RamData(RamData), .RamWren(RamWren),
        .RamQ(RamQ)
    );

    always #5 Clk = ~Clk;

    // 256x16 single-port RAM: registered inputs, q one cycle later
    logic [15:0] mem [256];
    always @(posedge Clk) begin
        if (RamWren) mem[RamAddr] <= RamData;
        RamQ <= mem[RamAddr];
    end

    typedef struct {
        logic        fetch;
        logic        we;
        logic [7:0]  addr;
        logic [15:0] wdata;
        logic [15:0] expd;
    } vec_t;

    vec_t        vecs [8];
    logic [15:0] shadow [256];
    logic [15:0] d_q [$];
    logic [15:0] f_q [$];
    int          wd_pend = 0;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expd);
        checks++;
        if (act !== expd) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expd);
        end
    endtask

    // Scoreboard: every completion pulse must match an outstanding expectation
    always @(negedge Clk) begin
        if (D_RValid) begin
            chk("D_RValid expected", 32'(d_q.size() != 0), 32'd1);
            if (d_q.size() != 0) chk("D_RData", 32'(D_RData), 32'(d_q.pop_front()));
        end
        if (F_RValid) begin
            chk("F_RValid expected", 32'(f_q.size() != 0), 32'd1);
            if (f_q.size() != 0) chk("F_RData", 32'(F_RData), 32'(f_q.pop_front()));
        end
        if (D_WDone) begin
            chk("D_WDone expected", 32'(wd_pend > 0), 32'd1);
            if (wd_pend > 0) wd_pend--;
        end
    end

    task automatic access(input logic fetch, input logic we, input logic [7:0] addr,
                          input logic [15:0] wdata, input logic [15:0] expd);
        int   n;
        logic got;
        logic wr;
        wr = we & ~fetch;
        @(negedge Clk);
        if (fetch) begin
            F_Req = 1'b1; F_Addr = addr;
        end else begin
            D_Req = 1'b1; D_We = we; D_Addr = addr; D_WData = wdata;
        end
        #1;
        n = 0;
        while (!(fetch ? F_Gnt : D_Gnt) && n < 20) begin
            @(negedge Clk); #1; n++;
        end
        chk("grant within bound", 32'(n < 20), 32'd1);
        if (n >= 20) begin
            D_Req = 1'b0; F_Req = 1'b0;
            return;
        end
        if (fetch)   f_q.push_back(expd);
        else if (wr) begin wd_pend++; shadow[addr] = wdata; end
        else         d_q.push_back(expd);
        @(posedge Clk); #1;
        D_Req = 1'b0; F_Req = 1'b0; D_We = 1'b0;
        n = 0; got = 1'b0;
        while (!got && n < 10) begin
            @(negedge Clk); #1; n++;
            if (n == 1) begin
                chk("RamWren in ISSUE", 32'(RamWren), 32'(wr));
                chk("RamAddr", 32'(RamAddr), 32'(addr));
                if (wr) chk("RamData", 32'(RamData), 32'(wdata));
            end
            if (n == 2) chk("RamWren one cycle", 32'(RamWren), 32'd0);
            got = fetch ? F_RValid : (wr ? D_WDone : D_RValid);
        end
        chk("completion latency", n, wr ? 2 : 3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        vecs[0] = '{1'b0, 1'b1, 8'h1A, 16'hBEEF, 16'h0000};
        vecs[1] = '{1'b0, 1'b0, 8'h1A, 16'h0000, 16'hBEEF};
        vecs[2] = '{1'b0, 1'b1, 8'hFF, 16'h1234, 16'h0000};
        vecs[3] = '{1'b0, 1'b1, 8'h00, 16'h5678, 16'h0000};
        vecs[4] = '{1'b1, 1'b0, 8'hFF, 16'h0000, 16'h1234};
        vecs[5] = '{1'b1, 1'b0, 8'h00, 16'h0000, 16'h5678};
        vecs[6] = '{1'b0, 1'b0, 8'h00, 16'h0000, 16'h5678};
        vecs[7] = '{1'b1, 1'b0, 8'h1A, 16'h0000, 16'hBEEF};

        repeat (2) @(negedge Clk);
        #1;
        chk("reset RamWren", 32'(RamWren), 32'd0);
        chk("reset RamAddr", 32'(RamAddr), 32'd0);
        chk("reset RamData", 32'(RamData), 32'd0);
        chk("reset D_RData", 32'(D_RData), 32'd0);
        chk("reset F_RData", 32'(F_RData), 32'd0);
        chk("reset pulses", 32'({D_RValid, F_RValid, D_WDone, D_Gnt, F_Gnt}), 32'd0);
        @(negedge Clk);
        ResetN = 1'b1;

        for (int i = 0; i < 8; i++) begin
            access(vecs[i].fetch, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].expd);
            if (i == 5) chk("D_RData unchanged by fetch", 32'(D_RData), 32'hBEEF);
        end

        // Contention: both ports held from reset, grants alternate D,F,D,F
        access(1'b0, 1'b1, 8'h2B, 16'h2B2B, 16'h0);
        access(1'b0, 1'b1, 8'h3C, 16'h3C3C, 16'h0);
        @(negedge Clk); ResetN = 1'b0;
        @(negedge Clk); ResetN = 1'b1;
        D_Req = 1'b1; D_We = 1'b0; D_Addr = 8'h2B; F_Req = 1'b1; F_Addr = 8'h3C;
        #1;
        for (int c = 0; c < 12; c++) begin
            chk("arb D_Gnt", 32'(D_Gnt), 32'(c % 6 == 0));
            chk("arb F_Gnt", 32'(F_Gnt), 32'(c % 6 == 3));
            if (D_Gnt) d_q.push_back(shadow[8'h2B]);
            if (F_Gnt) f_q.push_back(shadow[8'h3C]);
            @(negedge Clk); #1;
        end
        D_Req = 1'b0; F_Req = 1'b0;
        repeat (2) @(negedge Clk);

        // Write and fetch to the same address in the same cycle
        D_Req = 1'b1; D_We = 1'b1; D_Addr = 8'h4D; D_WData = 16'hAAAA;
        F_Req = 1'b1; F_Addr = 8'h4D;
        #1;
        chk("same-cycle D_Gnt", 32'(D_Gnt), 32'd1);
        chk("same-cycle F_Gnt", 32'(F_Gnt), 32'd0);
        wd_pend++; shadow[8'h4D] = 16'hAAAA; f_q.push_back(16'hAAAA);
        @(posedge Clk); #1;
        D_Req = 1'b0; D_We = 1'b0;
        n = 0;
        while (!F_Gnt && n < 10) begin @(negedge Clk); #1; n++; end
        chk("F grant after write", n, 2);
        @(posedge Clk); #1;
        F_Req = 1'b0;
        repeat (4) @(negedge Clk);

        // Reset during CAPTURE of a read: discarded, nothing reported
        D_Req = 1'b1; D_We = 1'b0; D_Addr = 8'h1A;
        #1;
        chk("abort read gnt", 32'(D_Gnt), 32'd1);
        @(posedge Clk); #1;
        D_Req = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        ResetN = 1'b0;
        #1;
        chk("capture reset RamAddr", 32'(RamAddr), 32'd0);
        chk("capture reset RamData", 32'(RamData), 32'd0);
        chk("capture reset D_RData", 32'(D_RData), 32'd0);
        chk("capture reset F_RData", 32'(F_RData), 32'd0);
        chk("capture reset flags", 32'({RamWren, D_RValid, F_RValid, D_WDone}), 32'd0);
        @(negedge Clk); ResetN = 1'b1;
        repeat (5) @(negedge Clk);
        access(1'b0, 1'b0, 8'h1A, 16'h0, 16'hBEEF);

        // Reset during ISSUE of a write: RamWren drops at once, write lost
        @(negedge Clk);
        D_Req = 1'b1; D_We = 1'b1; D_Addr = 8'h1A; D_WData = 16'h1111;
        #1;
        chk("abort write gnt", 32'(D_Gnt), 32'd1);
        @(posedge Clk); #1;
        D_Req = 1'b0; D_We = 1'b0;
        @(negedge Clk); #1;
        chk("RamWren in ISSUE", 32'(RamWren), 32'd1);
        ResetN = 1'b0;
        #1;
        chk("RamWren async clear", 32'(RamWren), 32'd0);
        @(negedge Clk); ResetN = 1'b1;
        access(1'b0, 1'b0, 8'h1A, 16'h0, shadow[8'h1A]);

        repeat (3) @(negedge Clk);
        chk("D reads drained", d_q.size(), 0);
        chk("F reads drained", f_q.size(), 0);
        chk("writes drained", wd_pend, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
